hidden_serializer: RTL and testbench

HIDDEN_SERIALIZER -- requirements
Module: hidden_serializer

---
 rtl/hidden_serializer_pkg.sv | 12 +
 rtl/hidden_serializer.sv | 120 ++++++++++++
 tb/tb_hidden_serializer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hidden_serializer_pkg.sv
// Shared network constants: layer dimensions, fixed-point format and the
// serializer state encodings.
package hidden_serializer_pkg;

  localparam int unsigned NET_D_WL       = 24;
  localparam int unsigned NET_FL         = 12;
  localparam int unsigned NET_INPUT_SIZE = 30;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

endpackage

// File: rtl/hidden_serializer.sv
// Turns a parallel hidden-layer vector into a stream of elements, one per cycle,
// with a one-deep pending slot so consecutive vectors stream back-to-back.
module hidden_serializer
  import hidden_serializer_pkg::*;
#(
  parameter int unsigned INPUT_SIZE = NET_INPUT_SIZE,
  parameter int unsigned D_WL       = NET_D_WL
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       v_valid,
  input  logic [INPUT_SIZE*D_WL-1:0] v_in,
  output logic                       v_ready,
  output logic                       o_valid,
  output logic [D_WL-1:0]            x,
  output logic                       last
);

  localparam int unsigned VW    = INPUT_SIZE * D_WL;
  localparam int unsigned CNT_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUT_SIZE - 1);

  logic [0:0]       state_q, state_d;
  logic [VW-1:0]    buf_q, buf_d;
  logic [VW-1:0]    pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             o_valid_q, o_valid_d;
  logic             last_q, last_d;
  logic [D_WL-1:0]  x_q, x_d;
  logic             xfer;
  logic             do_load;
  logic [VW-1:0]    load_vec;

  // rst_n is an active-high reset despite its name.
  assign v_ready = !pend_full_q && !rst_n;
  assign xfer    = v_valid && v_ready;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    o_valid_d   = o_valid_q;
    last_d      = last_q;
    x_d         = x_q;
    do_load     = 1'b0;
    load_vec    = '0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          do_load  = 1'b1;
          load_vec = v_in;
        end
      end
      STREAM: begin
        if (cnt_q != CNT_LAST) begin
          x_d    = buf_q[D_WL-1:0];
          buf_d  = buf_q >> D_WL;
          cnt_d  = cnt_inc;
          last_d = (cnt_inc == CNT_LAST);
          if (xfer) begin
            pend_d      = v_in;
            pend_full_d = 1'b1;
          end
        end else if (pend_full_q) begin
          do_load     = 1'b1;
          load_vec    = pend_q;
          pend_full_d = 1'b0;
        end else if (xfer) begin
          do_load  = 1'b1;
          load_vec = v_in;
        end else begin
          state_d   = IDLE;
          o_valid_d = 1'b0;
          last_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Element 0 goes straight to x; the buffer keeps the remaining elements.
    if (do_load) begin
      state_d   = STREAM;
      o_valid_d = 1'b1;
      x_d       = load_vec[D_WL-1:0];
      buf_d     = load_vec >> D_WL;
      cnt_d     = '0;
      last_d    = (CNT_LAST == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      o_valid_q   <= 1'b0;
      last_q      <= 1'b0;
      x_q         <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      o_valid_q   <= o_valid_d;
      last_q      <= last_d;
      x_q         <= x_d;
    end
  end

  assign o_valid = o_valid_q;
  assign last    = last_q;
  assign x       = x_q;

endmodule

// File: tb/tb_hidden_serializer.sv
// Scoreboard bench: each accepted vector queues its elements in order; the monitor
// expects o_valid exactly while elements are owed and checks x/last/v_ready.
module tb_hidden_serializer;

  localparam int unsigned N  = 30;
  localparam int unsigned W  = 24;
  localparam int unsigned VW = N * W;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } elem_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v_valid;
  logic [VW-1:0] v_in;
  logic          v_ready;
  logic          o_valid;
  logic [W-1:0]  x;
  logic          last;

  elem_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  logic  chk_reset = 1'b0;

  hidden_serializer #(.INPUT_SIZE(N), .D_WL(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .v_valid (v_valid),
    .v_in    (v_in),
    .v_ready (v_ready),
    .o_valid (o_valid),
    .x       (x),
    .last    (last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    elem_t e;
    check("v_ready", W'(v_ready), W'(!rst_n && exp_q.size() <= N));
    check("o_valid", W'(o_valid), W'(exp_q.size() > 0));
    if (chk_reset) begin
      check("reset_x", x, '0);
      chk_reset = 1'b0;
    end
    if (o_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("x", x, e.data);
      check("last", W'(last), W'(e.last));
    end else if (!o_valid) begin
      check("last_idle", W'(last), '0);
    end
    if (rst_n) begin
      exp_q.delete();
      chk_reset = 1'b1;
    end else if (v_valid && v_ready) begin
      for (int k = 0; k < N; k++) begin
        e.data = v_in[k*W +: W];
        e.last = (k == N - 1);
        exp_q.push_back(e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves v_valid asserted so back-to-back offers keep it high.
  task automatic offer(input logic [VW-1:0] v);
    logic ok;
    int   b;
    v_valid = 1'b1;
    v_in    = v;
    ok      = 1'b0;
    b       = 0;
    while (!ok && b < 200) begin
      ok = v_ready;
      cyc(1);
      b++;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL offer_timeout at %0t: got not accepted expected accepted", $time);
    end
  endtask

  task automatic drain();
    int b;
    v_valid = 1'b0;
    b = 0;
    while ((o_valid || exp_q.size() > 0) && b < 300) begin
      cyc(1);
      b++;
    end
    cyc(2);
    tests++;
    if (b >= 300) begin
      fails++;
      $display("FAIL drain_timeout at %0t: got %0d owed expected 0", $time, exp_q.size());
    end
  endtask

  function automatic logic [VW-1:0] ramp(input int base);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst_n   = 1'b1;
    v_valid = 1'b0;
    v_in    = '0;
    cyc(3);
    rst_n = 1'b0;
    cyc(2);

    // Single vector, elements 1..30.
    offer(ramp(1));
    drain();

    // Second vector offered mid-stream lands in the pending slot.
    offer(ramp(16'h100));
    cyc(4);
    offer(rnd_vec());
    drain();

    // Second vector offered exactly on the last-element cycle.
    offer(ramp(16'h200));
    v_valid = 1'b0;
    b = 0;
    while (!last && b < 100) begin
      cyc(1);
      b++;
    end
    offer(ramp(16'h300));
    drain();

    // v_valid held high across three vectors.
    offer(ramp(16'h400));
    offer(ramp(16'h500));
    offer(ramp(16'h600));
    drain();

    // Reset mid-stream with a vector pending.
    offer(rnd_vec());
    offer(rnd_vec());
    v_valid = 1'b0;
    cyc(10);
    rst_n = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    cyc(5);
    offer(ramp(16'h700));
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      v_valid = ($urandom_range(0, 3) != 0);
      v_in    = rnd_vec();
      rst_n   = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    rst_n = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
